data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and a
//  multi-cycle backing data memory. Acts as initiator toward the memory: on a miss it writes back a
//  dirty victim line, then refills word by word over a valid/ready request + response-valid port.
//  The CPU side uses a valid/ready request with a one-cycle output-valid strobe.
// PARAMETERS
//  NUM_SETS    16  lines in cache; power of 2
//  LINE_WORDS  4   32-bit words per line; power of 2
// PORTS
//  reset            in   1   synchronous, active-high
//  clk              in   1   single clock; all state updates on posedge
//  is_input_valid   in   1   CPU request valid
//  addr             in   32  byte address; [1:0] ignored
//  din              in   32  store data
//  mem_read         in   1   load request
//  mem_write        in   1   store request
//  is_ready         out  1   cache can accept a request this cycle
//  is_output_valid  out  1   one-cycle pulse: request completed
//  dout             out  32  load data; valid while is_output_valid && load
//  is_hit           out  1   completed request hit on first lookup; qualified by is_output_valid
//  mem_req_valid    out  1   memory beat request
//  mem_req_write    out  1   1 = write beat, 0 = read beat
//  mem_req_addr     out  32  word-aligned beat address
//  mem_req_wdata    out  32  write-beat data
//  mem_req_ready    in   1   memory accepts the beat this cycle
//  mem_resp_valid   in   1   read data returned
//  mem_resp_rdata   in   32  read data
//  hit_count        out  32  stats; see CONFIGURATION
//  miss_count       out  32  stats; see CONFIGURATION
// BEHAVIOUR
//  Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(NUM_SETS) bits, tag = rest.
//  Reset: all valid/dirty bits 0, state IDLE, every output 0 except is_ready (1 in IDLE), counters 0.
//   Reset mid-operation aborts: request dropped, no completion pulse, mem_req_valid 0 next cycle,
//   dirty data lost.
//  FSM:
//   IDLE: is_ready=1. Accept when is_input_valid && (mem_read||mem_write); latch addr/din/op.
//    A request with neither op is ignored. Both ops set: treated as a store. -> COMPARE.
//   COMPARE: hit = valid[index] && tag match.
//    Hit load: is_output_valid=1, dout=word -> IDLE.
//    Hit store: write word, dirty=1, is_output_valid=1 -> IDLE.
//    Miss: dirty victim -> WRITEBACK, else -> ALLOCATE.
//   WRITEBACK: beats 0..LINE_WORDS-1 at {victim_tag,index,beat,2'b00}, mem_req_write=1.
//    Beat counter advances only when mem_req_valid && mem_req_ready. After the last beat
//    -> ALLOCATE.
//   ALLOCATE: per word, issue read beat (mem_req_write=0), hold until mem_req_ready, then wait
//    for mem_resp_valid; at most one outstanding. After the last word: valid=1, dirty=0, tag set
//    -> COMPARE. The retry hits; is_hit=0 reported for that request.
//  mem_req_* stay stable while mem_req_valid && !mem_req_ready.
//  mem_resp_valid outside ALLOCATE-wait is ignored.
//  is_ready=0 in every state but IDLE. Hit latency: accept to is_output_valid = 1 cycle.
//  Miss latency = 2 + memory time; dirty miss adds LINE_WORDS write beats.
//  Offset/beat counters wrap at LINE_WORDS; no cross-line access.
// CONFIGURATION
//  DCACHE_STATS_EN defined: hit_count/miss_count increment once per completed request (first
//   lookup result) and saturate at 32'hFFFF_FFFF; cleared by reset.
//  DCACHE_STATS_EN undefined: ports present, tied to 0, no counter logic.
// TESTING
//  1. Load addr 0x40 after reset -> 4 read beats at 0x40,0x44,0x48,0x4C; then dout=mem[0x40],
//     is_hit=0.
//  2. Repeat load 0x44 -> is_output_valid 1 cycle after accept, is_hit=1, no mem_req_valid.
//  3. Store 0xDEADBEEF to 0x48, then load 0x48 + NUM_SETS*LINE_WORDS*4 (conflict) -> 4 write beats
//     at 0x40..0x4C with 0xDEADBEEF at 0x48, then 4 read beats.
//  4. mem_req_ready held low 5 cycles mid-writeback -> req fields stable, beat not skipped.
//  5. Assert reset during ALLOCATE beat 2 -> no is_output_valid; next load 0x40 misses again.
//  6. With DCACHE_STATS_EN: scenarios 1-3 -> hit_count=2, miss_count=2; without -> both 0.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// CPU side: valid/ready request, one-cycle completion strobe.
// Memory side: word-beat initiator (valid/ready request + response-valid).
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache #(
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        is_input_valid,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic [31:0] dout,
  output logic        is_hit,
  output logic        mem_req_valid,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_ALLOC_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [31:2]      r_addr;
  logic [31:0]      r_din;
  logic             r_is_store;
  logic             r_missed;
  logic [OFF_W-1:0] r_beat;
  logic [NUM_SETS-1:0] r_valid, r_dirty;
  logic [TAG_W-1:0] r_tag  [NUM_SETS];
  logic [31:0]      r_data [NUM_SETS*LINE_WORDS];

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_accept;
  logic             w_beat_last;
  logic             w_unused_addr;

  assign w_off       = r_addr[OFF_W+1:2];
  assign w_idx       = r_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag       = r_addr[31:OFF_W+IDX_W+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept    = is_input_valid && (mem_read || mem_write);
  assign w_beat_last = (r_beat == OFF_W'(LINE_WORDS - 1));
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and all state-decoded outputs
  always_comb begin
    w_next          = r_state;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    dout            = '0;
    is_hit          = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        is_ready = 1'b1;
        if (w_accept) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          is_output_valid = 1'b1;
          is_hit          = !r_missed;
          if (!r_is_store) dout = r_data[{w_idx, w_off}];
          w_next = S_IDLE;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {r_tag[w_idx], w_idx, r_beat, 2'b00};
        mem_req_wdata = r_data[{w_idx, r_beat}];
        if (mem_req_ready && w_beat_last) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_tag, w_idx, r_beat, 2'b00};
        if (mem_req_ready) w_next = S_ALLOC_WAIT;
      end
      S_ALLOC_WAIT: begin
        if (mem_resp_valid) w_next = w_beat_last ? S_COMPARE : S_ALLOCATE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, line state bits and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_din      <= '0;
      r_is_store <= 1'b0;
      r_missed   <= 1'b0;
      r_beat     <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= addr[31:2];
            r_din      <= din;
            r_is_store <= mem_write;
            r_missed   <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (r_is_store) r_dirty[w_idx] <= 1'b1;
          end else begin
            // Victim is dropped from lookup now; its tag and data stay intact
            // for the writeback, and a partly refilled line can never hit.
            r_missed       <= 1'b1;
            r_beat         <= '0;
            r_valid[w_idx] <= 1'b0;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        S_WRITEBACK: begin
          if (mem_req_ready) r_beat <= r_beat + OFF_W'(1);
        end
        S_ALLOC_WAIT: begin
          if (mem_resp_valid) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_beat_last) r_valid[w_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays (no reset; guarded by the valid bits)
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_COMPARE && w_hit && r_is_store)
        r_data[{w_idx, w_off}] <= r_din;
      if (r_state == S_ALLOC_WAIT && mem_resp_valid) begin
        r_data[{w_idx, r_beat}] <= mem_resp_rdata;
        if (w_beat_last) r_tag[w_idx] <= w_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  // Saturating per-request hit/miss counters, keyed on the first lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_COMPARE && w_hit) begin
      if (r_missed) begin
        if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
      end else begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a behavioural word memory.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_input_valid;
  logic [31:0] addr;
  logic [31:0] din;
  logic        mem_read;
  logic        mem_write;
  logic        is_ready;
  logic        is_output_valid;
  logic [31:0] dout;
  logic        is_hit;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready  = 1'b1;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
    .reset          (reset),
    .clk            (clk),
    .is_input_valid (is_input_valid),
    .addr           (addr),
    .din            (din),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .is_ready       (is_ready),
    .is_output_valid(is_output_valid),
    .dout           (dout),
    .is_hit         (is_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Beat log written by the memory model
  logic        lg_w [$];
  logic [31:0] lg_a [$];
  logic [31:0] lg_d [$];

  logic [31:0] mem [1024];
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  int          stall = 0;
  logic        arm_stall = 1'b0;
  logic        stall_seen = 1'b0;
  int          arm_wb = 0;
  logic        snap_ok = 1'b0;
  logic [31:0] snap_addr, snap_data;

  // Memory model: inputs change on negedge; a beat handshakes when valid&&ready
  // is seen here, its read data comes back one cycle later.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | (32'(i) << 2);
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend_data;
        pend = 1'b0;
      end
      if (stall > 0) begin
        mem_req_ready = 1'b0;
        stall--;
        if (!snap_ok) begin
          snap_addr = mem_req_addr;
          snap_data = mem_req_wdata;
          snap_ok   = 1'b1;
        end else begin
          check("stall_valid", {31'b0, mem_req_valid}, 32'd1);
          check("stall_addr", mem_req_addr, snap_addr);
          check("stall_wdata", mem_req_wdata, snap_data);
        end
      end else begin
        mem_req_ready = 1'b1;
        snap_ok = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        lg_w.push_back(mem_req_write);
        lg_a.push_back(mem_req_addr);
        lg_d.push_back(mem_req_wdata);
        if (mem_req_write) begin
          mem[mem_req_addr[11:2]] = mem_req_wdata;
          if (arm_stall) begin
            arm_wb++;
            if (arm_wb == 2) begin
              stall      = 5;
              arm_stall  = 1'b0;
              stall_seen = 1'b1;
            end
          end
        end else begin
          pend      = 1'b1;
          pend_data = mem[mem_req_addr[11:2]];
        end
      end
    end
  end

  // Issue one request from a negedge with the cache idle; wait for completion.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                        output logic [31:0] rdout, output logic rhit, output int lat);
    is_input_valid = 1'b1;
    addr = a; din = d; mem_read = rd; mem_write = wr;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    lat = 1;
    while (!is_output_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'b0, is_output_valid}, 32'd1);
    rdout = dout;
    rhit  = is_hit;
    @(negedge clk);
    check("pulse_len", {31'b0, is_output_valid}, 32'd0);
  endtask

  logic [31:0] r_d;
  logic        r_h;
  int          lat;
  int          base;
  int          n;
  int          pulses;
  logic [31:0] exp_wb [4];

  initial begin
    reset = 1'b1; is_input_valid = 1'b0; addr = '0; din = '0;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, is_ready}, 32'd1);
    check("rst_ovalid", {31'b0, is_output_valid}, 32'd0);
    check("rst_reqv", {31'b0, mem_req_valid}, 32'd0);
    check("rst_hitcnt", hit_count, 32'd0);
    check("rst_misscnt", miss_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: cold load miss, refill 0x40..0x4C
    base = lg_a.size();
    do_req(32'h40, 32'h0, 1'b1, 1'b0, r_d, r_h, lat);
    check("t1_beats", 32'(lg_a.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", lg_a[base+i], 32'(32'h40 + 4*i));
      check("t1_rd", {31'b0, lg_w[base+i]}, 32'd0);
    end
    check("t1_dout", r_d, 32'hA000_0040);
    check("t1_hit", {31'b0, r_h}, 32'd0);

    // 2: same-line load hits in one cycle with no memory traffic
    base = lg_a.size();
    do_req(32'h44, 32'h0, 1'b1, 1'b0, r_d, r_h, lat);
    check("t2_lat", 32'(lat), 32'd1);
    check("t2_hit", {31'b0, r_h}, 32'd1);
    check("t2_dout", r_d, 32'hA000_0044);
    check("t2_beats", 32'(lg_a.size() - base), 32'd0);

    // Request with neither op is ignored
    is_input_valid = 1'b1; addr = 32'h40;
    @(negedge clk);
    is_input_valid = 1'b0;
    check("noop_ready", {31'b0, is_ready}, 32'd1);
    check("noop_ovalid", {31'b0, is_output_valid}, 32'd0);

    // 3: store hit, then conflicting load forces dirty writeback (with a stall)
    do_req(32'h48, 32'hDEAD_BEEF, 1'b0, 1'b1, r_d, r_h, lat);
    check("t3_st_lat", 32'(lat), 32'd1);
    check("t3_st_hit", {31'b0, r_h}, 32'd1);
    base = lg_a.size();
    arm_stall = 1'b1;
    do_req(32'h148, 32'h0, 1'b1, 1'b0, r_d, r_h, lat);
    check("t4_stall_seen", {31'b0, stall_seen}, 32'd1);
    check("t3_beats", 32'(lg_a.size() - base), 32'd8);
    exp_wb[0] = 32'hA000_0040; exp_wb[1] = 32'hA000_0044;
    exp_wb[2] = 32'hDEAD_BEEF; exp_wb[3] = 32'hA000_004C;
    for (int i = 0; i < 4; i++) begin
      check("t3_wb_wr", {31'b0, lg_w[base+i]}, 32'd1);
      check("t3_wb_addr", lg_a[base+i], 32'(32'h40 + 4*i));
      check("t3_wb_data", lg_d[base+i], exp_wb[i]);
      check("t3_rf_wr", {31'b0, lg_w[base+4+i]}, 32'd0);
      check("t3_rf_addr", lg_a[base+4+i], 32'(32'h140 + 4*i));
    end
    check("t3_dout", r_d, 32'hA000_0148);
    check("t3_hit", {31'b0, r_h}, 32'd0);

`ifdef DCACHE_STATS_EN
    check("t6_hitcnt", hit_count, 32'd2);
    check("t6_misscnt", miss_count, 32'd2);
`else
    check("t6_hitcnt", hit_count, 32'd0);
    check("t6_misscnt", miss_count, 32'd0);
`endif

    // 5: reset while the refill of 0x80 is requesting beat 2
    is_input_valid = 1'b1; addr = 32'h80; mem_read = 1'b1;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0;
    n = 0;
    while (!(mem_req_valid && mem_req_addr == 32'h88) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_beat2_seen", {31'b0, mem_req_valid}, 32'd1);
    pulses = 0;
    reset = 1'b1;
    @(negedge clk);
    if (is_output_valid) pulses++;
    check("t5_reqv_off", {31'b0, mem_req_valid}, 32'd0);
    check("t5_ready", {31'b0, is_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (is_output_valid) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'd0);
    check("t5_hitcnt", hit_count, 32'd0);
    check("t5_misscnt", miss_count, 32'd0);
    base = lg_a.size();
    do_req(32'h40, 32'h0, 1'b1, 1'b0, r_d, r_h, lat);
    check("t5_hit", {31'b0, r_h}, 32'd0);
    check("t5_dout", r_d, 32'hA000_0040);
    check("t5_beats", 32'(lg_a.size() - base), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
